// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Moore-style main control FSM for a multi-cycle RV32I core.
//             Sequences fetch / decode / execute / memory / writeback over a
//             shared ALU, register file and unified memory. Memory accesses
//             wait on mem_ready, illegal opcodes park the FSM in TRAP with a
//             sticky flag, and retired instructions are counted.
//  Ports    :
//    clk           in   rising-edge clock
//    reset         in   asynchronous active-low reset
//    run           in   start fetching (sampled in IDLE only)
//    opcode[6:0]   in   instruction register bits [6:0]
//    zero          in   ALU zero flag (consumed by the datapath PC logic)
//    mem_ready     in   memory completes the current access this cycle
//    pc_write      out  unconditional PC update
//    pc_write_cond out  PC update when zero=1
//    ir_write      out  instruction register load
//    mem_read      out  memory read request
//    mem_write     out  memory write request
//    iord          out  memory address select: 0 = PC, 1 = ALUOut
//    reg_write     out  register file write enable
//    mem_to_reg    out  writeback select: 1 = MDR, 0 = ALUOut
//    alu_src_a     out  ALU A select: 0 = PC, 1 = rs1
//    alu_src_b[1:0]out  ALU B select: 00 = rs2, 01 = 4, 10 = immediate
//    alu_op[1:0]   out  00 = add, 01 = subtract, 10 = funct fields
//    illegal       out  sticky illegal-opcode flag
//    retired       out  retired-instruction count (wraps)
//    state_dbg[3:0]out  current state encoding
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  // The zero flag is resolved in the datapath together with pc_write_cond;
  // the FSM itself never branches on it.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  // --------------------------------------------------------------------------
  // State, sticky flag and retire counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      // Flag rises on the edge that enters TRAP so it is visible in TRAP.
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_FETCH;
        end
      end

      S_FETCH: begin
        // Request held for the whole wait; PC += 4 and IR load only on the
        // completing cycle so a stalled fetch does not advance the PC.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end

      S_DECODE: begin
        // Precompute PC + imm so BRANCH finds its target in ALUOut.
        alu_src_b = 2'b10;
        case (opcode)
          c_op_r:                w_next = S_EXEC_R;
          c_op_i:                w_next = S_EXEC_I;
          c_op_load, c_op_store: w_next = S_MEM_ADDR;
          c_op_branch:           w_next = S_BRANCH;
          default:               w_next = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_op_load) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_WR: begin
        // A store has no writeback, so it retires on the completing cycle.
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b00;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end

      S_TRAP: begin
        w_next = S_TRAP;
      end

      // Encodings 12..15 are unreachable; recover to IDLE if ever seen.
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign illegal   = r_illegal;
  assign retired   = r_retired;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Scoreboard bench for multicycle_control. The stimulus process
//             drives one cycle of inputs at a time and queues the expected
//             state, control vector, illegal flag and retire count for that
//             cycle; a monitor pops and compares on every falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  localparam int CNT_W = 32;

  // State encodings
  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2,
                         EXEC_R = 4'd3, EXEC_I = 4'd4, ALU_WB = 4'd5,
                         MEM_ADDR = 4'd6, MEM_RD = 4'd7, MEM_WB = 4'd8,
                         MEM_WR = 4'd9, BRANCH = 4'd10, TRAP = 4'd11;

  // Opcodes
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  // Control vector: {pc_write, pc_write_cond, ir_write, mem_read, mem_write,
  //                  iord, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op}
  localparam logic [12:0] C_NONE       = 13'b0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [12:0] C_FETCH_WAIT = 13'b0_0_0_1_0_0_0_0_0_01_00;
  localparam logic [12:0] C_FETCH_RDY  = 13'b1_0_1_1_0_0_0_0_0_01_00;
  localparam logic [12:0] C_DECODE     = 13'b0_0_0_0_0_0_0_0_0_10_00;
  localparam logic [12:0] C_EXEC_R     = 13'b0_0_0_0_0_0_0_0_1_00_10;
  localparam logic [12:0] C_EXEC_I     = 13'b0_0_0_0_0_0_0_0_1_10_10;
  localparam logic [12:0] C_ALU_WB     = 13'b0_0_0_0_0_0_1_0_0_00_00;
  localparam logic [12:0] C_MEM_ADDR   = 13'b0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [12:0] C_MEM_RD     = 13'b0_0_0_1_0_1_0_0_0_00_00;
  localparam logic [12:0] C_MEM_WB     = 13'b0_0_0_0_0_0_1_1_0_00_00;
  localparam logic [12:0] C_MEM_WR     = 13'b0_0_0_0_1_1_0_0_0_00_00;
  localparam logic [12:0] C_BRANCH     = 13'b0_1_0_0_0_0_0_0_1_00_01;

  logic             clk;
  logic             reset;
  logic             run;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic             iord, reg_write, mem_to_reg, alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal       (illegal),
    .retired       (retired),
    .state_dbg     (state_dbg)
  );

  logic [12:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                     iord, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [3:0]       st;
    logic [12:0]      ctrl;
    logic             ill;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               step_id = 0;
  logic             exp_ill = 1'b0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic chk(input string name, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state_dbg", e.id, 32'(state_dbg), 32'(e.st));
      chk("controls",  e.id, 32'(act_ctrl),  32'(e.ctrl));
      chk("illegal",   e.id, 32'(illegal),   32'(e.ill));
      chk("retired",   e.id, 32'(retired),   32'(e.ret));
    end
  end

  // One cycle: drive inputs, queue what the DUT must show, advance.
  task automatic step(input logic r, input logic [6:0] op, input logic rdy,
                      input logic [3:0] st, input logic [12:0] c);
    exp_t e;
    run       = r;
    opcode    = op;
    mem_ready = rdy;
    e.id   = step_id;
    e.st   = st;
    e.ctrl = c;
    e.ill  = exp_ill;
    e.ret  = exp_ret;
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Idle with run low: nothing moves, all controls quiet.
    for (int i = 0; i < 10; i++) step(1'b0, OP_R, 1'b1, IDLE, C_NONE);

    // R-type, run dropped mid-instruction, mem_ready ignored outside memory states
    step(1'b1, OP_R, 1'b1, IDLE,   C_NONE);
    step(1'b0, OP_R, 1'b1, FETCH,  C_FETCH_RDY);
    step(1'b0, OP_R, 1'b0, DECODE, C_DECODE);
    step(1'b0, OP_R, 1'b0, EXEC_R, C_EXEC_R);
    step(1'b0, OP_R, 1'b0, ALU_WB, C_ALU_WB);
    exp_ret = 1;

    // I-type
    step(1'b0, OP_I, 1'b1, FETCH,  C_FETCH_RDY);
    step(1'b0, OP_I, 1'b1, DECODE, C_DECODE);
    step(1'b0, OP_I, 1'b1, EXEC_I, C_EXEC_I);
    step(1'b0, OP_I, 1'b1, ALU_WB, C_ALU_WB);
    exp_ret = 2;

    // Load with 3 fetch wait cycles and 2 read wait cycles: 10 cycles
    for (int i = 0; i < 3; i++) step(1'b0, OP_LD, 1'b0, FETCH, C_FETCH_WAIT);
    step(1'b0, OP_LD, 1'b1, FETCH,    C_FETCH_RDY);
    step(1'b0, OP_LD, 1'b0, DECODE,   C_DECODE);
    step(1'b0, OP_LD, 1'b0, MEM_ADDR, C_MEM_ADDR);
    for (int i = 0; i < 2; i++) step(1'b0, OP_LD, 1'b0, MEM_RD, C_MEM_RD);
    step(1'b0, OP_LD, 1'b1, MEM_RD,   C_MEM_RD);
    step(1'b0, OP_LD, 1'b0, MEM_WB,   C_MEM_WB);
    exp_ret = 3;

    // Store, no waits: 4 cycles
    step(1'b0, OP_ST, 1'b1, FETCH,    C_FETCH_RDY);
    step(1'b0, OP_ST, 1'b1, DECODE,   C_DECODE);
    step(1'b0, OP_ST, 1'b1, MEM_ADDR, C_MEM_ADDR);
    step(1'b0, OP_ST, 1'b1, MEM_WR,   C_MEM_WR);
    exp_ret = 4;

    // Store with 2 write wait cycles; retire only on the ready cycle
    step(1'b0, OP_ST, 1'b1, FETCH,    C_FETCH_RDY);
    step(1'b0, OP_ST, 1'b0, DECODE,   C_DECODE);
    step(1'b0, OP_ST, 1'b0, MEM_ADDR, C_MEM_ADDR);
    step(1'b0, OP_ST, 1'b0, MEM_WR,   C_MEM_WR);
    step(1'b0, OP_ST, 1'b0, MEM_WR,   C_MEM_WR);
    step(1'b0, OP_ST, 1'b1, MEM_WR,   C_MEM_WR);
    exp_ret = 5;

    // Branch: 3 cycles
    step(1'b0, OP_BR, 1'b1, FETCH,  C_FETCH_RDY);
    step(1'b0, OP_BR, 1'b1, DECODE, C_DECODE);
    step(1'b0, OP_BR, 1'b1, BRANCH, C_BRANCH);
    exp_ret = 6;

    // Store stalled in MEM_WR, then asynchronous reset between edges
    step(1'b0, OP_ST, 1'b1, FETCH,    C_FETCH_RDY);
    step(1'b0, OP_ST, 1'b1, DECODE,   C_DECODE);
    step(1'b0, OP_ST, 1'b1, MEM_ADDR, C_MEM_ADDR);
    begin
      exp_t e;
      mem_ready = 1'b0;
      e.id = step_id; e.st = MEM_WR; e.ctrl = C_MEM_WR; e.ill = exp_ill; e.ret = exp_ret;
      exp_q.push_back(e);
      step_id++;
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_mem_write", step_id, 32'(mem_write), 32'd0);
    chk("async_rst_state",     step_id, 32'(state_dbg), 32'(IDLE));
    chk("async_rst_retired",   step_id, 32'(retired),   32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_request", step_id, 32'({mem_read, mem_write}), 32'd0);
    reset   = 1'b1;
    exp_ret = '0;
    step(1'b0, OP_ST, 1'b0, IDLE, C_NONE);

    // Counter wrap: preload all-ones, retire one branch
    force dut.r_retired = {CNT_W{1'b1}};
    #1 release dut.r_retired;
    exp_ret = {CNT_W{1'b1}};
    step(1'b1, OP_BR, 1'b1, IDLE,   C_NONE);
    step(1'b0, OP_BR, 1'b1, FETCH,  C_FETCH_RDY);
    step(1'b0, OP_BR, 1'b1, DECODE, C_DECODE);
    step(1'b0, OP_BR, 1'b1, BRANCH, C_BRANCH);
    exp_ret = '0;

    // Illegal opcode: TRAP for 20 cycles regardless of run / mem_ready
    step(1'b0, OP_BAD, 1'b1, FETCH,  C_FETCH_RDY);
    step(1'b0, OP_BAD, 1'b1, DECODE, C_DECODE);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) step(i[0], OP_BAD, i[1], TRAP, C_NONE);

    // Reset clears the sticky flag and returns to IDLE
    reset = 1'b0;
    #1;
    chk("trap_rst_illegal", step_id, 32'(illegal),   32'd0);
    chk("trap_rst_state",   step_id, 32'(state_dbg), 32'(IDLE));
    @(posedge clk);
    #1 reset = 1'b1;
    exp_ill = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, OP_R, 1'b1, IDLE, C_NONE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for a multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback over one shared ALU, register file and unified memory.
- Drives ALUOp to the ALU control decoder: 00 = add (address/PC arithmetic), 01 = subtract (branch compare), 10 = use funct fields.
- Handles memory wait states through a ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  leave IDLE and start fetching when high.
- opcode  in  7  instruction register bits [6:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if zero=1.
- ir_write  out  1  load the instruction register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  to the ALU control decoder.
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  retired-instruction count.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, retired=0, illegal=0. All control outputs are 0 while in IDLE.
- State register and counter update on the rising edge of clk. Control outputs are a pure decode of the state, except where qualified by mem_ready as noted below.
- States and encodings:
  - IDLE(0): go to FETCH when run=1.
  - FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
    - ir_write=1 and pc_write=1 only in the cycle with mem_ready=1.
    - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(2): alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - anything else -> TRAP
  - EXEC_R(3): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALU_WB.
  - EXEC_I(4): alu_src_a=1, alu_src_b=10, alu_op=10. Next: ALU_WB.
  - ALU_WB(5): reg_write=1, mem_to_reg=0. Retire. Next: FETCH.
  - MEM_ADDR(6): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD if opcode=0000011, else MEM_WR.
  - MEM_RD(7): mem_read=1, iord=1. Hold until mem_ready=1, then MEM_WB.
  - MEM_WB(8): reg_write=1, mem_to_reg=1. Retire. Next: FETCH.
  - MEM_WR(9): mem_write=1, iord=1. Hold until mem_ready=1. Retire in the mem_ready cycle. Next: FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1. Retire. Next: FETCH.
  - TRAP(11): illegal set to 1 on entry. All control outputs are 0. Stay in TRAP until reset.
  - Undefined encodings (12–15) go to IDLE.
- Retire means retired increments by 1 on the exiting clock edge and wraps modulo 2^CNT_W.
- Latency without wait states: R/I = 4 cycles, load = 5, store = 4, branch = 3. Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect; the FSM never returns to IDLE except through reset or an undefined state.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- mem_read and mem_write are held stable for the whole wait period.
- mem_read and mem_write are never both 1. pc_write and pc_write_cond are never both 1.
- Reset mid-access: everything returns to IDLE immediately. No further memory request is issued.

Test Plan:
- Reset low for 2 cycles, then high with run=0 -> state_dbg=0, all outputs 0, retired=0 after 10 cycles.
- run=1, mem_ready=1, opcode=0110011 -> states 1,2,3,5,1. alu_op=10 in state 3. reg_write=1 for exactly one cycle. retired=1.
- Load (0000011) with mem_ready=0 for 3 cycles in FETCH and for 2 cycles in MEM_RD -> total 10 cycles. ir_write pulses once. mem_to_reg=1 in MEM_WB. retired increments once.
- Branch (1100011) -> BRANCH reached in the 3rd cycle with alu_op=01 and pc_write_cond=1. Store (0100011) -> mem_write=1, iord=1, no reg_write, 4 cycles.
- opcode=1111111 -> TRAP: illegal=1 and all controls 0 for 20 cycles. Reset then clears illegal to 0 and state to IDLE.
- Reset asserted asynchronously mid-MEM_WR with mem_ready=0 -> mem_write drops before the next clock edge. Separately, preload retired to all-ones via force, retire one instruction -> retired=0.
